// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns PC and S/Z flags, fetches 16-bit instructions over req/ack,
// resolves conditional jumps locally and dispatches everything else to the datapath.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [3:0] ALU_CODE  = 4'b0110,
  parameter logic [3:0] JMP_CODE  = 4'b0101,
  parameter logic [3:0] HALT_CODE = 4'b0000,
  parameter logic [3:0] NOP_CODE  = 4'b0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        ex_valid,
  output logic [3:0]  ex_ins,
  output logic [3:0]  ex_fun,
  output logic [7:0]  ex_imm,
  input  logic        ex_ready,
  input  logic [7:0]  alu_res,
  input  logic        alu_zf,
  output logic [7:0]  pc,
  output logic        jmp_taken,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } seqState_e;

  seqState_e   state, stateNext;
  logic [7:0]  pcReg, pcNext;
  logic [15:0] ir, irNext;
  logic        sFlag, sNext;
  logic        zFlag, zNext;
  logic        jmpReg, jmpNext;
  logic        jmpCond;
  logic        unusedAluBits;

  logic [3:0] insField;
  logic [3:0] funField;
  logic [7:0] immField;

  assign insField = ir[15:12];
  assign funField = ir[11:8];
  assign immField = ir[7:0];

  // Only the sign bit of the ALU result feeds the flags.
  assign unusedAluBits = ^alu_res[6:0];

  always_comb begin
    case (funField)
      4'b0000: jmpCond = !sFlag;
      4'b0001: jmpCond = !sFlag || !zFlag;
      4'b0010: jmpCond = !zFlag;
      4'b0011: jmpCond = zFlag;
      4'b0100: jmpCond = sFlag;
      4'b0101: jmpCond = sFlag || !zFlag;
      default: jmpCond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pcReg  <= RESET_PC;
      ir     <= '0;
      sFlag  <= 1'b0;
      zFlag  <= 1'b0;
      jmpReg <= 1'b0;
    end else begin
      state  <= stateNext;
      pcReg  <= pcNext;
      ir     <= irNext;
      sFlag  <= sNext;
      zFlag  <= zNext;
      jmpReg <= jmpNext;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pcReg;
    irNext    = ir;
    sNext     = sFlag;
    zNext     = zFlag;
    jmpNext   = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pcNext    = RESET_PC;
          stateNext = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          irNext    = imem_rdata;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        if (insField == HALT_CODE) begin
          stateNext = HALT;
        end else if (insField == NOP_CODE) begin
          pcNext    = pcReg + 8'd2;
          stateNext = FETCH;
        end else if (insField == JMP_CODE) begin
          // Registered pulse lands in the first FETCH cycle after DECODE.
          if (jmpCond) begin
            pcNext  = immField;
            jmpNext = 1'b1;
          end else begin
            pcNext = pcReg + 8'd2;
          end
          stateNext = FETCH;
        end else begin
          stateNext = EXEC;
        end
      end
      EXEC: begin
        if (ex_ready) begin
          pcNext = pcReg + 8'd2;
          if (insField == ALU_CODE) begin
            sNext = alu_res[7];
            zNext = alu_zf;
          end
          stateNext = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pcReg;
  assign pc        = pcReg;
  assign ex_valid  = (state == EXEC);
  assign ex_ins    = (state == EXEC) ? insField : '0;
  assign ex_fun    = (state == EXEC) ? funField : '0;
  assign ex_imm    = (state == EXEC) ? immField : '0;
  assign jmp_taken = jmpReg;
  assign halted    = (state == HALT);

endmodule
